// File: rtl/instr_loader_pkg.sv
// Shared types for the instruction loader: FSM states, error codes and the
// supported RV32I major-opcode list used by the optional opcode check.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_TIMEOUT = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_CHK     = 3'd3;
   localparam logic [2:0] ERR_OPCODE  = 3'd4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   function automatic logic opcode_ok(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_REG, OP_BRANCH, OP_IMM,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_ok = 1'b1;
         default:                           opcode_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream in from the UART receiver and word-write bus out to instruction
// memory. The loader is the master of this bundle.
interface instr_loader_if #(parameter int ADDR_W = 10);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (input rx_data, rx_valid, output imem_we, imem_addr, imem_wdata);
   modport slave  (output rx_data, rx_valid, input imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Collects little-endian payload bytes into 32-bit words and keeps the running
// XOR of every payload byte since the last clear.
module word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_in,
   output logic        word_vld,
   output logic [31:0] word,
   output logic [7:0]  chk
);

   logic [1:0]  idx;
   logic [23:0] shift_p0;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         idx <= 2'd0;
         chk <= 8'd0;
      end else if (byte_vld) begin
         idx <= idx + 2'd1;
         chk <= chk ^ byte_in;
      end
   end

   // Oldest byte ends up in the low lane once three bytes have arrived.
   always_ff @(posedge clk) begin
      if (byte_vld) shift_p0 <= {byte_in, shift_p0[23:8]};
   end

   assign word_vld = byte_vld && (idx == 2'd3);
   assign word     = {byte_in, shift_p0};

endmodule

// File: rtl/instr_loader.sv
// UART boot loader: parses LEN/payload/CHK frames into instruction-memory writes
// and holds the CPU in reset while loading. Define OPCODE_CHECK_EN to reject words
// whose major opcode is not a supported RV32I one.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   instr_loader_if.master        bus,
   output logic                  cpu_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            err_code
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
   localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

   state_t      state, state_nxt;
   logic [2:0]  err_nxt;
   logic [15:0] len;
   logic [15:0] len_val;
   logic [15:0] word_cnt;
   logic [31:0] to_cnt;
   logic        in_rst;
   logic        load_start;
   logic        write;
   logic        expire;
   logic        op_bad;
   logic        last_word;
   logic        word_vld;
   logic [31:0] word;
   logic [7:0]  chk;

   assign busy       = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CHK);
   assign done       = (state == S_DONE);
   assign cpu_rst_n  = !in_rst && ((state == S_IDLE) || (state == S_DONE));
   assign load_start = start && !busy;
   assign len_val    = {bus.rx_data, len[7:0]};
   assign last_word  = (word_cnt == len - 16'd1);
   // A byte arriving on the expiry cycle clears the counter instead.
   assign expire     = busy && !bus.rx_valid && (to_cnt == TO_LAST);

`ifdef OPCODE_CHECK_EN
   assign op_bad = !opcode_ok(word[6:0]);
`else
   assign op_bad = 1'b0;
`endif

   word_assembler u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (load_start),
      .byte_vld (bus.rx_valid && (state == S_DATA)),
      .byte_in  (bus.rx_data),
      .word_vld (word_vld),
      .word     (word),
      .chk      (chk)
   );

   always_comb begin
      state_nxt = state;
      err_nxt   = err_code;
      write     = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_LEN0;
               err_nxt   = ERR_NONE;
            end
         end
         S_LEN0: if (bus.rx_valid) state_nxt = S_LEN1;
         S_LEN1: begin
            if (bus.rx_valid) begin
               if ({16'd0, len_val} > MAX_LEN) begin
                  state_nxt = S_ERR;
                  err_nxt   = ERR_LEN;
               end else if (len_val == 16'd0) begin
                  state_nxt = S_CHK;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_vld) begin
               if (op_bad) begin
                  state_nxt = S_ERR;
                  err_nxt   = ERR_OPCODE;
               end else begin
                  write = 1'b1;
                  if (last_word) state_nxt = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == chk) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_ERR;
                  err_nxt   = ERR_CHK;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (expire) begin
         state_nxt = S_ERR;
         err_nxt   = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         err_code <= ERR_NONE;
         in_rst   <= 1'b1;
      end else begin
         state    <= state_nxt;
         err_code <= err_nxt;
         in_rst   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || load_start || bus.rx_valid || !busy) to_cnt <= 32'd0;
      else                                              to_cnt <= to_cnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (bus.rx_valid && (state == S_LEN0)) len[7:0]  <= bus.rx_data;
      if (bus.rx_valid && (state == S_LEN1)) len[15:8] <= bus.rx_data;
   end

   // Write stage: registered one cycle after the word's 4th byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt       <= 16'd0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= 32'd0;
      end else begin
         bus.imem_we <= write;
         if (load_start) begin
            word_cnt      <= 16'd0;
            bus.imem_addr <= '0;
         end else if (write) begin
            word_cnt       <= word_cnt + 16'd1;
            bus.imem_addr  <= ADDR_W'(word_cnt);
            bus.imem_wdata <= word;
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a byte-count based frame model checked
// every cycle, plus literal expectations at scenario boundaries.
module tb_instr_loader;

   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cpu_rst_n, busy, done;
   logic [2:0] err_code;

   instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: outcome depends only on how many bytes the frame has received.
   logic              m_load = 1'b0, m_done = 1'b0, m_in_rst = 1'b1, m_we = 1'b0;
   int                m_err = 0, m_idle = 0, nb = 0, n = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [31:0]       m_wdata = '0, w;
   logic [7:0]        x;
   logic [7:0]        m_bytes[$];
   bit                cmp_en = 1'b0;

   function automatic bit op_supported(input logic [6:0] op);
`ifdef OPCODE_CHECK_EN
      logic [6:0] ops[9] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17};
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
`else
      return (op == op) ? 1'b1 : 1'b1;
`endif
   endfunction

   always @(posedge clk) begin
      m_we = 1'b0;
      if (!rst_n) begin
         m_load = 1'b0; m_done = 1'b0; m_err = 0; m_in_rst = 1'b1;
         m_addr = '0; m_wdata = '0; m_bytes.delete();
      end else begin
         m_in_rst = 1'b0;
         if (!m_load) begin
            if (start) begin
               m_load = 1'b1; m_done = 1'b0; m_err = 0; m_idle = 0; n = 0;
               m_addr = '0; m_bytes.delete();
            end
         end else if (bus.rx_valid) begin
            m_idle = 0;
            m_bytes.push_back(bus.rx_data);
            nb = m_bytes.size();
            if (nb >= 2) n = int'({m_bytes[1], m_bytes[0]});
            if (nb == 2) begin
               if (n > (1 << ADDR_W)) begin m_load = 1'b0; m_err = 2; end
            end else if (nb > 2 && nb <= 2 + 4 * n) begin
               if ((nb - 2) % 4 == 0) begin
                  w = {m_bytes[nb-1], m_bytes[nb-2], m_bytes[nb-3], m_bytes[nb-4]};
                  if (!op_supported(w[6:0])) begin
                     m_load = 1'b0; m_err = 4;
                  end else begin
                     m_we = 1'b1; m_addr = ADDR_W'((nb - 2) / 4 - 1); m_wdata = w;
                  end
               end
            end else if (nb == 3 + 4 * n) begin
               x = 8'h00;
               for (int i = 2; i < nb - 1; i++) x ^= m_bytes[i];
               m_load = 1'b0;
               if (x == m_bytes[nb-1]) m_done = 1'b1;
               else                    m_err  = 3;
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_load = 1'b0; m_err = 1; end
         end
      end
   end

   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];

   always @(negedge clk) begin
      if (bus.imem_we) begin
         log_addr.push_back(bus.imem_addr);
         log_data.push_back(bus.imem_wdata);
      end
      if (cmp_en) begin
         check("busy", 32'(busy), 32'(m_load));
         check("done", 32'(done), 32'(m_done));
         check("err_code", 32'(err_code), 32'(m_err));
         check("cpu_rst_n", 32'(cpu_rst_n), 32'(!m_in_rst && !m_load && m_err == 0));
         check("imem_we", 32'(bus.imem_we), 32'(m_we));
         check("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
         check("imem_wdata", bus.imem_wdata, m_wdata);
      end
   end

   function automatic logic [31:0] log_d(input int i);
      return (i >= 0 && i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] log_a(input int i);
      return (i >= 0 && i < log_addr.size()) ? 32'(log_addr[i]) : 32'hDEAD_BEEF;
   endfunction

   logic [7:0] fb[$];

   task automatic tick(input int cycles);
      repeat (cycles) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data = b; bus.rx_valid = 1'b1; tick(1); bus.rx_valid = 1'b0;
   endtask

   task automatic send_fb();
      foreach (fb[i]) send(fb[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   int         base;
   logic [7:0] cs;
   logic [31:0] wd;

   initial begin
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
      tick(1);
      cmp_en = 1'b1;
      tick(2);
      check("rst_imem_we", 32'(bus.imem_we), 32'd0);
      check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
      check("rst_imem_wdata", bus.imem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_code), 32'd0);
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      rst_n = 1'b1;
      tick(1);
      check("cpu_rst_n_release", 32'(cpu_rst_n), 32'd1);

      // start with a coincident byte; the byte must be dropped
      start = 1'b1; bus.rx_data = 8'h55; bus.rx_valid = 1'b1;
      tick(1);
      start = 1'b0; bus.rx_valid = 1'b0;
      // checksum of 93 00 50 00 13 01 10 00 is 0xC1
      fb = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
      send_fb();
      tick(2);
      check("s1_nwrites", 32'(log_data.size()), 32'd2);
      check("s1_addr0", log_a(0), 32'd0);
      check("s1_data0", log_d(0), 32'h00500093);
      check("s1_addr1", log_a(1), 32'd1);
      check("s1_data1", log_d(1), 32'h00100113);
      check("s1_done", 32'(done), 32'd1);
      check("s1_err", 32'(err_code), 32'd0);
      check("s1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

      // empty frames, byte while DONE ignored
      send(8'hAA);
      pulse_start();
      fb = '{8'h00, 8'h00, 8'h00};
      send_fb();
      tick(1);
      check("n0_done", 32'(done), 32'd1);
      check("n0_nwrites", 32'(log_data.size()), 32'd2);
      pulse_start();
      fb = '{8'h00, 8'h00, 8'h01};
      send_fb();
      tick(1);
      check("n0bad_err", 32'(err_code), 32'd3);
      check("n0bad_done", 32'(done), 32'd0);

      // length one past the memory size, then exactly the memory size
      pulse_start();
      send(8'h05); send(8'h00);
      check("len5_err", 32'(err_code), 32'd2);
      check("len5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      tick(2);
      check("len5_nwrites", 32'(log_data.size()), 32'd2);
      pulse_start();
      fb = '{8'h04, 8'h00};
      cs = 8'h00;
      for (int i = 0; i < 4; i++) begin
         wd = 32'h00000013 | (32'(i) << 8);
         for (int k = 0; k < 4; k++) begin
            fb.push_back(wd[8*k +: 8]);
            cs ^= wd[8*k +: 8];
         end
      end
      fb.push_back(cs);
      send_fb();
      tick(1);
      check("len4_done", 32'(done), 32'd1);
      check("len4_addr3", log_a(5), 32'd3);
      check("len4_data3", log_d(5), 32'h00000313);

      // stall after the 2nd payload byte
      pulse_start();
      fb = '{8'h01, 8'h00, 8'h13, 8'h00};
      send_fb();
      tick(TIMEOUT - 1);
      check("to_before_busy", 32'(busy), 32'd1);
      tick(1);
      check("to_err", 32'(err_code), 32'd1);
      check("to_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      // a byte on the expiry cycle keeps the load alive
      pulse_start();
      send_fb();
      tick(TIMEOUT - 1);
      send(8'h00); send(8'h00); send(8'h13);
      tick(1);
      check("to_retry_done", 32'(done), 32'd1);
      check("to_retry_data", log_d(log_data.size() - 1), 32'h00000013);

      // word with an unsupported opcode field
      base = log_data.size();
      pulse_start();
      fb = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
      send_fb();
      tick(1);
`ifdef OPCODE_CHECK_EN
      check("opc_err", 32'(err_code), 32'd4);
      check("opc_nwrites", 32'(log_data.size()), 32'(base));
`else
      check("opc_done", 32'(done), 32'd1);
      check("opc_data", log_d(base), 32'hFFFFFFFF);
`endif

      // reset mid-DATA, then start while busy
      pulse_start();
      fb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
      send_fb();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_err", 32'(err_code), 32'd0);
      check("mid_we", 32'(bus.imem_we), 32'd0);
      check("mid_addr", 32'(bus.imem_addr), 32'd0);
      check("mid_wdata", bus.imem_wdata, 32'd0);
      check("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      tick(1);
      base = log_data.size();
      pulse_start();
      fb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      send_fb();
      pulse_start();
      fb = '{8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
      send_fb();
      tick(1);
      check("busy_start_done", 32'(done), 32'd1);
      check("busy_start_a0", log_a(base), 32'd0);
      check("busy_start_d0", log_d(base), 32'h00000013);
      check("busy_start_a1", log_a(base + 1), 32'd1);
      check("busy_start_d1", log_d(base + 1), 32'h00500093);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
